// File: rtl/cmp_pkg.sv
// Shared types and constants for the shared L/E/G comparator controller.
package cmp_pkg;

  typedef enum logic [2:0] {
    OP_SLT  = 3'd0,
    OP_SLTU = 3'd1,
    OP_FEQ  = 3'd2,
    OP_FLT  = 3'd3,
    OP_FLE  = 3'd4
  } cmp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMP,
    ST_RESP
  } ctrl_state_e;

  localparam logic [7:0]  FP_EXP_ALL1 = 8'hFF;
  localparam logic [31:0] SIGN_BIAS   = 32'h8000_0000;

  typedef struct packed {
    cmp_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
  } cmp_req_t;

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == FP_EXP_ALL1) && (x[22:0] != '0);
  endfunction

endpackage

// File: rtl/cmp_cond.sv
// Operand conditioning for the shared unsigned comparator and result/NV selection.
module cmp_cond
  import cmp_pkg::*;
(
  input  cmp_op_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_lt,
  input  logic        i_eq,
  input  logic        i_gt,
  output logic [31:0] o_cmp_a,
  output logic [31:0] o_cmp_b,
  output logic        o_result,
  output logic        o_nv
);

  logic a_nan, b_nan, a_snan, b_snan, any_nan;
  logic both_zero, fp_lt, fp_eq;

  // Operand select kept apart from result select so the comparator path is acyclic.
  always_comb begin
    o_cmp_a = '0;
    o_cmp_b = '0;
    case (i_op)
      OP_SLTU: begin
        o_cmp_a = i_a;
        o_cmp_b = i_b;
      end
      OP_SLT: begin
        o_cmp_a = i_a ^ SIGN_BIAS;
        o_cmp_b = i_b ^ SIGN_BIAS;
      end
      OP_FEQ, OP_FLT, OP_FLE: begin
        o_cmp_a = {1'b0, i_a[30:0]};
        o_cmp_b = {1'b0, i_b[30:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    a_nan     = fp_is_nan(i_a);
    b_nan     = fp_is_nan(i_b);
    a_snan    = a_nan && !i_a[22];
    b_snan    = b_nan && !i_b[22];
    any_nan   = a_nan || b_nan;
    both_zero = (i_a[30:0] == '0) && (i_b[30:0] == '0);
    fp_lt     = 1'b0;
    fp_eq     = 1'b0;
    if (both_zero) begin
      fp_eq = 1'b1;
    end else if (i_a[31] != i_b[31]) begin
      fp_lt = i_a[31];
    end else if (i_a[31]) begin
      // Both negative: larger magnitude is the smaller value.
      fp_lt = i_gt;
      fp_eq = i_eq;
    end else begin
      fp_lt = i_lt;
      fp_eq = i_eq;
    end

    o_result = 1'b0;
    o_nv     = 1'b0;
    case (i_op)
      OP_SLT, OP_SLTU: o_result = i_lt;
      OP_FEQ: begin
        o_result = !any_nan && fp_eq;
        o_nv     = a_snan || b_snan;
      end
      OP_FLT: begin
        o_result = !any_nan && fp_lt;
        o_nv     = any_nan;
      end
      OP_FLE: begin
        o_result = !any_nan && (fp_lt || fp_eq);
        o_nv     = any_nan;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cmp_share_ctrl.sv
// Two-port round-robin controller sharing one 32-bit L/E/G comparator.
module cmp_share_ctrl
  import cmp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter logic        RR_INIT = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [2:0]      i_req0_op,
  input  logic [XLEN-1:0] i_req0_a,
  input  logic [XLEN-1:0] i_req0_b,
  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [2:0]      i_req1_op,
  input  logic [XLEN-1:0] i_req1_a,
  input  logic [XLEN-1:0] i_req1_b,
  output logic            o_rsp0_valid,
  input  logic            i_rsp0_ready,
  output logic [XLEN-1:0] o_rsp0_result,
  output logic            o_rsp1_valid,
  input  logic            i_rsp1_ready,
  output logic [XLEN-1:0] o_rsp1_result,
  output logic            o_rsp1_nv
);

  ctrl_state_e state_q, state_d;
  cmp_req_t    req_q, req_d;
  logic        last_grant_q, last_grant_d;
  logic        gid_q, gid_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic        result_q, result_d;
  logic        nv_q, nv_d;

  logic        gnt0, gnt1;
  logic [31:0] cmp_a, cmp_b;
  logic        cmp_lt, cmp_eq, cmp_gt;
  logic        cond_result, cond_nv;

  // Ties go to the port that was not granted last.
  always_comb begin
    gnt0 = (state_q == ST_IDLE) && i_req0_valid && (!i_req1_valid || last_grant_q);
    gnt1 = (state_q == ST_IDLE) && i_req1_valid && (!i_req0_valid || !last_grant_q);
  end

  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;

  // The shared comparator only ever sees the latched, conditioned operands.
  always_comb begin
    cmp_lt = cmp_a < cmp_b;
    cmp_eq = cmp_a == cmp_b;
    cmp_gt = cmp_a > cmp_b;
  end

  cmp_cond u_cond (
    .i_op    (req_q.op),
    .i_a     (req_q.a),
    .i_b     (req_q.b),
    .i_lt    (cmp_lt),
    .i_eq    (cmp_eq),
    .i_gt    (cmp_gt),
    .o_cmp_a (cmp_a),
    .o_cmp_b (cmp_b),
    .o_result(cond_result),
    .o_nv    (cond_nv)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    last_grant_d = last_grant_q;
    gid_d        = gid_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    result_d     = result_q;
    nv_d         = nv_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt0) begin
          req_d        = '{op: cmp_op_e'(i_req0_op), a: i_req0_a, b: i_req0_b};
          gid_d        = 1'b0;
          last_grant_d = 1'b0;
          state_d      = ST_CMP;
        end else if (gnt1) begin
          req_d        = '{op: cmp_op_e'(i_req1_op), a: i_req1_a, b: i_req1_b};
          gid_d        = 1'b1;
          last_grant_d = 1'b1;
          state_d      = ST_CMP;
        end
      end
      ST_CMP: begin
        result_d     = cond_result;
        nv_d         = cond_nv && gid_q;
        rsp0_valid_d = !gid_q;
        rsp1_valid_d = gid_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (gid_q ? i_rsp1_ready : i_rsp0_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      last_grant_q <= RR_INIT;
      gid_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      result_q     <= 1'b0;
      nv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      last_grant_q <= last_grant_d;
      gid_q        <= gid_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      result_q     <= result_d;
      nv_q         <= nv_d;
    end
  end

  assign o_rsp0_valid  = rsp0_valid_q;
  assign o_rsp1_valid  = rsp1_valid_q;
  assign o_rsp0_result = {{(XLEN-1){1'b0}}, result_q};
  assign o_rsp1_result = {{(XLEN-1){1'b0}}, result_q};
  assign o_rsp1_nv     = nv_q;

endmodule

// File: doc/cmp_share_ctrl.md
Name: cmp_share_ctrl

Overview:
- Sequences and arbitrates one shared 32-bit unsigned L/E/G magnitude comparator between two requesters:
  - Port 0: integer ALU, for SLT and SLTU.
  - Port 1: FPU, for FEQ.S, FLT.S and FLE.S.
- Handles request handshake, round-robin grant, operand pre-conditioning (signed bias, FP sign/NaN/zero rules) and a held response.
- Sits between the execute-stage requesters and the comparator datapath.

Parameters:
- XLEN, 32, operand width. Fixed at 32 to match the comparator.
- RR_INIT, 1, initial value of the last-grant register. With 1, port 0 wins the first tie.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset. Synchronous, active-low.
- i_req0_valid  in  1  port-0 request valid.
- o_req0_ready  out  1  port-0 request accepted this cycle when valid&ready.
- i_req0_op  in  3  port-0 opcode (cmp_op_e).
- i_req0_a, i_req0_b  in  32  port-0 operands.
- i_req1_valid, o_req1_ready, i_req1_op, i_req1_a, i_req1_b: same as port 0, for port 1.
- o_rsp0_valid  out  1  port-0 response valid.
- i_rsp0_ready  in  1  port-0 response consumed.
- o_rsp0_result  out  32  port-0 result: 0 or 1, zero-extended.
- o_rsp1_valid, i_rsp1_ready, o_rsp1_result: same as port 0, for port 1.
- o_rsp1_nv  out  1  invalid-operation flag (fflags.NV) for a port-1 response.

Behaviour:
- Opcodes: SLT=0, SLTU=1, FEQ=2, FLT=3, FLE=4. Codes 5–7 are illegal: result 0, NV 0, normal handshake.
- Either port may issue any opcode. NV is reported on port 1 only.
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - o_reqX_ready = 1 for both ports.
  - One request pending: grant it.
  - Both pending: grant the port not in last_grant, then update last_grant.
  - On grant: latch op, a, b and grant id; go to CMP. The ungranted port sees ready=1 but is not accepted.
  - Correction, binding: o_req0_ready and o_req1_ready are the grant signals, combinational from valids and last_grant, asserted only in IDLE.
- CMP:
  - Both readies are 0.
  - Drive the comparator from conditioned operands. Latch result and nv; go to RESP.
- RESP:
  - o_rspX_valid = 1 for the granted port only.
  - result and nv stay stable until i_rspX_ready.
  - On ready: go to IDLE. No new request is accepted in the same cycle.
- Latency: accept at cycle N, response valid at N+2. Throughput is at most one op per 3 cycles.
- Operand conditioning:
  - SLTU: compare a, b directly. result = L.
  - SLT: compare a^0x8000_0000 with b^0x8000_0000. result = L.
  - FP: NaN means exp==0xFF and mant!=0. sNaN additionally has mant[22]==0.
  - FP, any NaN: result 0.
    - FEQ: NV=1 only if a or b is sNaN.
    - FLT/FLE: NV=1 whenever either operand is a NaN.
  - FP, both zero (a[30:0]==0 and b[30:0]==0): treat as equal.
  - FP, signs differ and not both zero: the negative operand is less.
  - FP, same sign: the comparator compares {1'b0,a[30:0]} vs {1'b0,b[30:0]}. If both are negative, swap the L and G meaning.
  - FP results: FEQ = eq; FLT = lt; FLE = lt|eq.
- Comparator: purely combinational, used only in CMP. Its inputs are muxed from the latched operands, never from live request buses.
- Reset, applied at any state, next edge:
  - state = IDLE, last_grant = RR_INIT.
  - All o_rsp*_valid = 0, results = 0, o_rsp1_nv = 0.
  - An in-flight op is dropped with no response.
- Valid held low during RESP has no effect. A requester must not drop a valid before acceptance; a dropped valid is not checked.

Decomposition:
- Package cmp_pkg holds:
  - cmp_op_e enum (3 bit).
  - Constants FP_EXP_ALL1 = 8'hFF, SIGN_BIAS = 32'h8000_0000.
  - Typedef cmp_req_t {op, a, b}.
- Sub-module cmp_cond: combinational operand conditioning and result select. Inputs: op, a, b, and comparator L/E/G. Outputs: comparator operands, result, nv. The top holds FSM, arbiter and registers, and instantiates the shared 32-bit comparator once.

Test Plan:
- Port-0 SLTU, a=0x0000_0001, b=0xFFFF_FFFF; accept cycle N -> o_rsp0_valid at N+2, result=1. Same operands as SLT -> result=0.
- Both valid in the same IDLE cycle after reset: port-0 FLT(1.0=0x3F80_0000, 2.0=0x4000_0000), port-1 FLE(-0.0=0x8000_0000, +0.0=0x0000_0000).
  - First: port 0 granted, result=1.
  - Next IDLE: port 1 granted, result=1, nv=0.
  - Third tie: port 0 granted.
- Port-1 FEQ(qNaN 0x7FC0_0000, 1.0) -> result 0, nv 0. FEQ(sNaN 0x7F80_0001, 1.0) -> result 0, nv 1. FLT(qNaN, 1.0) -> result 0, nv 1.
- Port-1 FLT(-2.0=0xC000_0000, -1.0=0xBF80_0000) -> result 1. FLT(-1.0, -2.0) -> result 0.
- Response backpressure: i_rsp1_ready held 0 for 5 cycles -> o_rsp1_valid and result stable, both req readies 0. Ready at cycle 6 -> IDLE next cycle.
- i_rst_n=0 for one cycle while in CMP -> next cycle IDLE, no rsp_valid; a subsequent SLTU(3,2) -> result 0 at N+2.
